shift_register_univ: RTL and testbench
======================================

# shift_register_univ

Parametrised universal shift register: the multi-bit, mode-selectable successor to the single-bit D flip-flop. Holds a WIDTH-bit word that can be held, shifted left or right with serial fill, or parallel-loaded every clock. A shift counter with a `done` flag supports serial-to-parallel and parallel-to-serial conversion. It sits between serial links and word-wide datapaths.

## Interface
Parameters:
- `WIDTH`, 8, register width in bits; legal range 2..64.
- `RESET_VAL`, 0, value loaded into `q` on reset; WIDTH bits.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `en`  input  1  clock enable; when 0, all state holds.
- `mode`  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `d`  input  WIDTH  parallel load data.
- `sin_r`  input  1  serial input for shift right; enters at `q[WIDTH-1]`.
- `sin_l`  input  1  serial input for shift left; enters at `q[0]`.
- `rot`  input  1  rotate select; present only when `USR_ROTATE_EN` is defined.
- `q`  output  WIDTH  register contents.
- `sout_r`  output  1  equals `q[0]`, combinational from `q`.
- `sout_l`  output  1  equals `q[WIDTH-1]`, combinational from `q`.
- `cnt`  output  $clog2(WIDTH+1)  number of shifts since the last load or reset; saturates at WIDTH.
- `done`  output  1  registered; 1 when `cnt == WIDTH`.

## Operation
- Priority: `rst` first, then `en`, then `mode`.
- Reset: `q` = RESET_VAL, `cnt` = 0, `done` = 0. `sout_r` and `sout_l` follow from RESET_VAL.
- `en` = 0: `q`, `cnt` and `done` hold, regardless of `mode`.
- Hold (00): `q`, `cnt` and `done` unchanged.
- Shift right (01): `q` <= {sin_r, q[WIDTH-1:1]}.
- Shift left (10): `q` <= {q[WIDTH-2:0], sin_l}.
- Parallel load (11): `q` <= `d`, `cnt` <= 0, `done` <= 0.
- Counter on any shift:
  - `cnt` <= min(`cnt`+1, WIDTH).
  - `done` <= 1 when the next value of `cnt` equals WIDTH.
  - Shifts after saturation keep moving `q`; `cnt` stays at WIDTH and `done` stays at 1.
- Mixing left and right shifts counts each one; the counter does not track direction.

## Timing
- Single-cycle latency: the `q`, `cnt` and `done` values take effect at the same rising edge as the command.
- Inputs are sampled only at the rising edge; no combinational path from `d`, `mode` or `sin_*` to any output.
- `sout_*` change only when `q` changes (same cycle as `q`).
- If `rst` is asserted in the middle of a serial sequence, the next edge returns to the reset state and the shift history is discarded.
- If `rst` and `en` are both asserted with mode 11, reset wins: `q` = RESET_VAL, not `d`.
- A load issued the cycle after `done` rises clears `done` at that edge, so `done` is high for exactly one cycle.

## Configuration
- Macro: `USR_ROTATE_EN`.
- Defined:
  - Input `rot` exists.
  - With `rot` = 1, shift right gives {q[0], q[WIDTH-1:1]} and shift left gives {q[WIDTH-2:0], q[WIDTH-1]}, and `sin_*` are ignored.
  - With `rot` = 1, rotates still increment `cnt`.
  - With `rot` = 0, behaviour is identical to the undefined build.
- Undefined: port `rot` is absent; shifts always fill from `sin_*`.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=8'hA5.
- Reset: hold `rst`=1 for 2 cycles with random inputs -> `q`=A5, `cnt`=0, `done`=0, `sout_r`=1, `sout_l`=1.
- Load then shift right 8 times with `sin_r`=1:
  - Load `d`=8'h3C, then shift right 8 times with `sin_r`=1 -> `q`=8'hFF.
  - `sout_r` sequence is 0,0,1,1,1,1,0,0.
  - `cnt` steps 1..8; `done` rises on the 8th edge.
  - A 9th shift -> `cnt`=8, `done`=1.
- Shift left 8 times, then load:
  - From `q`=00, shift left 8 times with `sin_l` pattern 1,0,1,1,0,0,1,0 -> `q`=8'hB2, `done`=1.
  - Then load `d`=8'h00 -> `cnt`=0, `done`=0 on the same edge.
- Enable gating: with `en`=0, `mode`=01 for 5 cycles -> `q`, `cnt` and `done` unchanged. With `en`=1, `mode`=00 -> also unchanged.
- Reset priority:
  - `rst`=1, `en`=1, `mode`=11, `d`=8'h5A -> `q`=A5.
  - Reset asserted after 4 shifts -> `cnt`=0.
- Rotate, with `USR_ROTATE_EN` defined:
  - Load 8'h81, `rot`=1, shift left once -> `q`=8'h03.
  - 7 more left rotates -> `q`=8'h81, `done`=1.
  - Same sequence with `rot`=0 and `sin_l`=0 -> `q`=8'h00.

Source files
------------

// File: rtl/shift_register_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load, with saturating shift counter and done flag (rotate via USR_ROTATE_EN).
// Latency: single cycle; q, cnt and done update on the same rising edge as the command.
// Backpressure: none; en=0 freezes all state, no inputs are ever refused.
module shift_register_univ #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin_r,
    input  logic                       sin_l,
`ifdef USR_ROTATE_EN
    input  logic                       rot,
`endif
    output logic [WIDTH-1:0]           q,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_nxt;
    logic             fill_r;
    logic             fill_l;
    logic             shifting;

`ifdef USR_ROTATE_EN
    // Rotation recirculates the bit falling off the opposite end instead of the serial input.
    assign fill_r = rot ? q[0]       : sin_r;
    assign fill_l = rot ? q[WIDTH-1] : sin_l;
`else
    assign fill_r = sin_r;
    assign fill_l = sin_l;
`endif

    always_comb begin
        q_nxt    = q;
        cnt_nxt  = cnt;
        done_nxt = done;
        shifting = 1'b0;
        case (mode)
            MODE_HOLD: ;
            MODE_RIGHT: begin
                q_nxt    = {fill_r, q[WIDTH-1:1]};
                shifting = 1'b1;
            end
            MODE_LEFT: begin
                q_nxt    = {q[WIDTH-2:0], fill_l};
                shifting = 1'b1;
            end
            MODE_LOAD: begin
                q_nxt    = d;
                cnt_nxt  = '0;
                done_nxt = 1'b0;
            end
            default: ;
        endcase
        // Direction-agnostic count, saturating so done stays high while shifting continues.
        if (shifting) begin
            cnt_nxt  = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
            done_nxt = (cnt_nxt == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RESET_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else if (en) begin
            q    <= q_nxt;
            cnt  <= cnt_nxt;
            done <= done_nxt;
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_shift_register_univ.sv
// Directed bench for shift_register_univ (WIDTH=8, RESET_VAL=A5): a word-level model checked every cycle plus literal expectations.
module tb_shift_register_univ;

    logic       clk = 1'b0;
    logic       rst, en, sin_r, sin_l, rot;
    logic [1:0] mode;
    logic [7:0] d;
    logic [7:0] q;
    logic       sout_r, sout_l, done;
    logic [3:0] cnt;

    int errors = 0;
    int checks = 0;

    // Reference state, updated once per clock edge from the applied command.
    logic [7:0] m_q;
    int         m_cnt;
    bit         m_done;
    bit         chk_en = 1'b0;

    always #5 clk = ~clk;

    shift_register_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
`ifdef USR_ROTATE_EN
        .rot    (rot),
`endif
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .cnt    (cnt),
        .done   (done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one command for one clock, then advance the model.
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] dd, input logic sr, input logic sl, input logic ro);
        bit use_rot;
        @(negedge clk);
        rst = r; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl; rot = ro;
        @(posedge clk);
        #1;
`ifdef USR_ROTATE_EN
        use_rot = ro;
`else
        use_rot = 1'b0;
`endif
        if (r) begin
            m_q = 8'hA5; m_cnt = 0; m_done = 1'b0;
        end else if (e) begin
            if (m == 2'b11) begin
                m_q = dd; m_cnt = 0; m_done = 1'b0;
            end else if (m != 2'b00) begin
                if (m == 2'b01)
                    m_q = (m_q >> 1) | ((use_rot ? {7'd0, m_q[0]} : {7'd0, sr}) << 7);
                else
                    m_q = (m_q << 1) | (use_rot ? {7'd0, m_q[7]} : {7'd0, sl});
                m_cnt  = (m_cnt + 1 > 8) ? 8 : m_cnt + 1;
                m_done = (m_cnt == 8);
            end
        end
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q", q, m_q);
            chk("model_cnt", cnt, m_cnt);
            chk("model_done", done, m_done);
            chk("model_sout_r", sout_r, m_q[0]);
            chk("model_sout_l", sout_l, m_q[7]);
        end
    end

    initial begin
        logic [7:0] sr_exp;
        logic [7:0] sl_pat;
        sr_exp = 8'b0011_1100;  // sout_r sequence 0,0,1,1,1,1,0,0 read LSB first
        sl_pat = 8'b0100_1101;  // sin_l sequence 1,0,1,1,0,0,1,0 read LSB first
        rst = 1'b1; en = 1'b0; mode = 2'b00; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;

        // Reset with random surrounding inputs
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        chk("rst_q", q, 8'hA5);
        chk("rst_cnt", cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_sout_r", sout_r, 1);
        chk("rst_sout_l", sout_l, 1);

        // Load 3C then shift right with sin_r=1
        step(1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("load_q", q, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sout_r_%0d", i), sout_r, sr_exp[i]);
            step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
            chk($sformatf("shr_cnt_%0d", i), cnt, i + 1);
            chk($sformatf("shr_done_%0d", i), done, (i == 7) ? 1 : 0);
        end
        chk("shr_q", q, 8'hFF);
        step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("sat_cnt", cnt, 8);
        chk("sat_done", done, 1);

        // Shift left pattern from zero, then load clears done on the same edge
        step(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, sl_pat[i], 1'b0);
        chk("shl_q", q, 8'hB2);
        chk("shl_done", done, 1);
        step(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reload_cnt", cnt, 0);
        chk("reload_done", done, 0);

        // Enable gating and hold mode
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 2'b01, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("en0_q", q, 8'h07);
        chk("en0_cnt", cnt, 3);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("hold_q", q, 8'h07);
        chk("hold_cnt", cnt, 3);

        // Reset priority over load, and mid-sequence reset
        step(1'b1, 1'b1, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("rstpri_q", q, 8'hA5);
        step(1'b0, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("mid_cnt_pre", cnt, 4);
        step(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_q", q, 8'hA5);

`ifdef USR_ROTATE_EN
        step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rotl_q1", q, 8'h03);
        for (int i = 0; i < 7; i++)
            step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rotl_q8", q, 8'h81);
        chk("rotl_done", done, 1);
        step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rotr_q1", q, 8'hC0);
        step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("norot_q", q, 8'h00);
`endif

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
